// File: rtl/mem_sram_access.sv
// Memory-stage load/store controller driving an SRAM-like addr_ok/data_ok port.
// Latency: minimum 3 cycles from op visible to result_valid (start, REQ, WAIT -> DONE).
// Backpressure: memory_stall holds EX/MEM until DONE; DONE holds result while wb_stall.
module mem_sram_access (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic        in_wr,
    input  logic [1:0]  in_size,
    input  logic        in_signed,
    input  logic        in_exc,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        flush,
    input  logic        wb_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic        memory_stall,
    output logic        result_valid,
    output logic [31:0] load_result
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        DONE    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] result_q, result_d;

    logic        start;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ext_rdata;

    // A new op is only accepted from IDLE; faulting or flushed ops never reach the port.
    assign start = (state_q == IDLE) & in_valid & ~in_exc & ~flush;

    // Select the addressed byte/half lane from the returned word and extend it.
    always_comb begin
        lane_byte = data_rdata[7:0];
        lane_half = data_rdata[15:0];
        ext_rdata = data_rdata;
        case (addr_q[1:0])
            2'd0:    lane_byte = data_rdata[7:0];
            2'd1:    lane_byte = data_rdata[15:8];
            2'd2:    lane_byte = data_rdata[23:16];
            default: lane_byte = data_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size_q)
            2'd0:    ext_rdata = {{24{signed_q & lane_byte[7]}}, lane_byte};
            2'd1:    ext_rdata = {{16{signed_q & lane_half[15]}}, lane_half};
            default: ext_rdata = data_rdata;
        endcase
    end

    // Next-state and latch logic for the access FSM.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = REQ;
                    wr_d     = in_wr;
                    // Size 3 is issued as a word so the port only ever sees 0..2.
                    size_d   = (in_size == 2'd3) ? 2'd2 : in_size;
                    signed_d = in_signed;
                    addr_d   = in_addr;
                    // Replicate store data across lanes; the SRAM picks lanes by addr/size.
                    case (in_size)
                        2'd0:    wdata_d = {4{in_wdata[7:0]}};
                        2'd1:    wdata_d = {2{in_wdata[15:0]}};
                        default: wdata_d = in_wdata;
                    endcase
                end
            end
            REQ: begin
                if (data_addr_ok && !flush)      state_d = WAIT;
                else if (data_addr_ok && flush)  state_d = DISCARD;
                else if (flush)                  state_d = IDLE;
            end
            WAIT: begin
                if (data_data_ok && !flush) begin
                    state_d  = DONE;
                    result_d = wr_q ? 32'd0 : ext_rdata;
                end else if (data_data_ok && flush) begin
                    state_d = IDLE;
                end else if (flush) begin
                    // Request already accepted: must still swallow its data_ok.
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (data_data_ok) state_d = IDLE;
            end
            DONE: begin
                if (!wb_stall || flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction latches; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
        end
    end

    // Request fields come straight from the latches so they are stable while REQ waits.
    assign data_req     = (state_q == REQ);
    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wdata   = wdata_q;

    // Stall is dropped in DONE so EX/MEM advances on the DONE->IDLE edge.
    assign memory_stall = start | (state_q == REQ) | (state_q == WAIT) | (state_q == DISCARD);
    assign result_valid = (state_q == DONE) & ~flush;
    assign load_result  = result_q;

endmodule
